// File: rtl/fp16_sq_pkg.sv
// Shared definitions for the FP16 iterative squaring unit: FSM states,
// FP16 format constants and the leading-zero count used to normalize
// subnormal operands.
package fp16_sq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        PACK
    } state_t;

    localparam int          FP16_BIAS     = 15;
    localparam logic [4:0]  FP16_EXP_MAX  = 5'h1F;
    localparam logic [9:0]  FP16_QNAN_BIT = 10'h200;
    localparam logic [15:0] FP16_PINF     = 16'h7C00;
    localparam int          MUL_ITERS     = 11;

    // Leading zeros of a 10-bit fraction; returns 10 for an all-zero input.
    function automatic logic [3:0] clz10(input logic [9:0] v);
        clz10 = 4'd10;
        for (int i = 0; i < 10; i++) begin
            if (v[i]) clz10 = 4'(9 - i);
        end
    endfunction

endpackage

// File: rtl/fp16_sq_pack.sv
// Combinational result packer for the squaring unit: turns the 22-bit
// product and unbiased operand exponent into an FP16 word, handling
// overflow to +inf, subnormal right shift, flush to zero and specials.
// Optional round-to-nearest-even under FP16_SQUARE_ROUND_EN
// (truncation when the macro is undefined).
module fp16_sq_pack
    import fp16_sq_pkg::*;
(
    input  logic [21:0]       prod,
    input  logic signed [6:0] exp_in,
    input  logic              is_zero,
    input  logic              is_inf,
    input  logic              is_nan,
    input  logic              nan_sign,
    input  logic [9:0]        nan_frac,
    output logic [15:0]       result
);

    logic signed [6:0] exp_res;
    logic signed [7:0] biased;
    logic [7:0]        sub_sh;
    logic              is_sub;
    logic [10:0]       sig;
    logic [3:0]        sh;
    logic [10:0]       mant_t;
    logic [14:0]       base;
    logic              inc;
    logic [15:0]       rounded;

    // Exponent, significand selection and (possibly subnormal) alignment.
    always_comb begin
        exp_res = (exp_in <<< 1) + $signed({6'b0, prod[21]});
        biased  = $signed({exp_res[6], exp_res}) + $signed(8'(FP16_BIAS));
        sub_sh  = 8'($signed(8'sd1) - biased);
        is_sub  = (biased <= 8'sd0);
        sig     = prod[21] ? prod[21:11] : prod[20:10];
        sh      = is_sub ? sub_sh[3:0] : 4'd0;
        mant_t  = sig >> sh;
        base    = is_sub ? {4'b0, mant_t} : {biased[4:0], mant_t[9:0]};
    end

`ifdef FP16_SQUARE_ROUND_EN
    logic [10:0] disc;
    logic [21:0] full;
    logic [21:0] shifted;
    logic [21:0] low_mask;
    logic        guard;
    logic        sticky;

    // Round-to-nearest-even from the bits dropped by the product select and shift.
    always_comb begin
        disc     = prod[21] ? prod[10:0] : {prod[9:0], 1'b0};
        full     = {sig, disc};
        shifted  = full >> sh;
        guard    = shifted[10];
        low_mask = (22'd1 << (5'(sh) + 5'd10)) - 22'd1;
        sticky   = |(full & low_mask);
        inc      = guard & (sticky | mant_t[0]);
    end
`else
    logic unused_bits;
    assign unused_bits = ^prod[9:0];
    assign inc = 1'b0;
`endif

    // A carry out of the fraction lands in the exponent field, which also
    // turns a rounded-up subnormal into min-normal and 30.max into +inf.
    assign rounded = {1'b0, base} + 16'(inc);

    // Final selection: specials first, then overflow, flush, numeric.
    always_comb begin
        if (is_nan)
            result = {nan_sign, FP16_EXP_MAX, nan_frac | FP16_QNAN_BIT};
        else if (is_inf)
            result = FP16_PINF;
        else if (is_zero)
            result = 16'h0000;
        else if (biased >= 8'sd31)
            result = FP16_PINF;
        else if (is_sub && (sub_sh >= 8'd12))
            result = 16'h0000;
        else
            result = rounded;
    end

endmodule

// File: rtl/fp16_square_iter.sv
// Sequential FP16 squaring unit: out = in * in using a radix-2 shift-add
// mantissa multiplier, one partial product per clock (11 MUL cycles plus
// one PACK cycle). Specials and zero skip the multiply.
// Optional rounding: define FP16_SQUARE_ROUND_EN for round-to-nearest-even.
module fp16_square_iter
    import fp16_sq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] in_data,
    output logic        busy,
    output logic        valid,
    output logic [15:0] out_data
);

    state_t            state;
    logic [3:0]        cnt;
    logic [10:0]       mcand;
    logic [10:0]       mplier;
    logic [21:0]       acc;
    logic signed [6:0] exp_e;
    logic              zero_f;
    logic              inf_f;
    logic              nan_f;
    logic              nan_sign;
    logic [9:0]        nan_frac;

    logic [4:0]        in_exp;
    logic [9:0]        in_frac;
    logic              d_nan;
    logic              d_inf;
    logic              d_zero;
    logic [3:0]        norm_sh;
    logic [10:0]       d_mant;
    logic signed [6:0] d_exp;
    logic [3:0]        bit_idx;
    logic [15:0]       pack_res;

    // Operand decode: classify and normalize subnormals to a hidden-one mantissa.
    always_comb begin
        in_exp  = in_data[14:10];
        in_frac = in_data[9:0];
        d_nan   = (in_exp == FP16_EXP_MAX) && (in_frac != 10'd0);
        d_inf   = (in_exp == FP16_EXP_MAX) && (in_frac == 10'd0);
        d_zero  = (in_exp == 5'd0) && (in_frac == 10'd0);
        norm_sh = clz10(in_frac) + 4'd1;
        if (in_exp == 5'd0) begin
            d_mant = {1'b0, in_frac} << norm_sh;
            d_exp  = $signed(7'sd1) - $signed(7'(FP16_BIAS)) - $signed({3'b0, norm_sh});
        end else begin
            d_mant = {1'b1, in_frac};
            d_exp  = $signed({2'b00, in_exp}) - $signed(7'(FP16_BIAS));
        end
    end

    // Multiplier bit being consumed this MUL cycle (counter runs 10 down to 0).
    assign bit_idx = 4'(MUL_ITERS - 1) - cnt;

    fp16_sq_pack u_pack (
        .prod     (acc),
        .exp_in   (exp_e),
        .is_zero  (zero_f),
        .is_inf   (inf_f),
        .is_nan   (nan_f),
        .nan_sign (nan_sign),
        .nan_frac (nan_frac),
        .result   (pack_res)
    );

    // Control FSM with the shift-add datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            valid    <= 1'b0;
            out_data <= 16'h0000;
            cnt      <= 4'd0;
            mcand    <= 11'd0;
            mplier   <= 11'd0;
            acc      <= 22'd0;
            exp_e    <= 7'sd0;
            zero_f   <= 1'b0;
            inf_f    <= 1'b0;
            nan_f    <= 1'b0;
            nan_sign <= 1'b0;
            nan_frac <= 10'd0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy     <= 1'b1;
                        mcand    <= d_mant;
                        mplier   <= d_mant;
                        acc      <= 22'd0;
                        cnt      <= 4'(MUL_ITERS - 1);
                        exp_e    <= d_exp;
                        zero_f   <= d_zero;
                        inf_f    <= d_inf;
                        nan_f    <= d_nan;
                        nan_sign <= in_data[15];
                        nan_frac <= in_frac;
                        state    <= (d_zero | d_inf | d_nan) ? PACK : MUL;
                    end
                end
                MUL: begin
                    if (mplier[0])
                        acc <= acc + (22'(mcand) << bit_idx);
                    mplier <= mplier >> 1;
                    cnt    <= cnt - 4'd1;
                    if (cnt == 4'd0)
                        state <= PACK;
                end
                PACK: begin
                    valid    <= 1'b1;
                    busy     <= 1'b0;
                    out_data <= pack_res;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/fp16_square_iter.md
# fp16_square_iter

Sequential FP16 squaring unit: computes `out = in × in` with a radix-2 shift-add mantissa multiplier, one partial product per clock. It is the inverse-direction companion of the FP16 square-root datapath. It uses the same unpack conventions (signed 7-bit unbiased exponent, 11-bit mantissa with hidden bit) and the same FP16 special-value rules, so a sqrt→square round trip can be checked in-system.

## Interface
Parameters:
- none; the format is fixed at FP16 (1/5/10).

Ports:
- `clk`  in  1  — single clock; all state changes on rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `start`  in  1  — request. Sampled only in IDLE; ignored while `busy`.
- `in_data`  in  16  — FP16 operand, captured on the accepted `start` edge.
- `busy`  out  1  — high from the accepting edge until the edge that asserts `valid`.
- `valid`  out  1  — one-cycle pulse; `out_data` is the new result in that cycle.
- `out_data`  out  16  — FP16 result; holds its value until the next `valid`.

## Operation
- States:
  - IDLE: on `start`, go to MUL, or to PACK if the input is a special or zero.
  - MUL: runs 11 cycles, then goes to PACK.
  - PACK: runs 1 cycle, then returns to IDLE.
- Capture edge:
  - Decode zero, subnormal, normal, inf and NaN.
  - Normalize subnormals with a CLZ. Exponent e lies in [-24, 15]; mantissa m is 11 bits with bit 10 set.
  - Load multiplicand = m, multiplier = m, 22-bit accumulator = 0, counter = 10.
- MUL, each cycle:
  - If the multiplier LSB is 1, add the multiplicand, shifted left by the bit index, into the accumulator.
  - Shift the multiplier right by one and decrement the counter.
  - Leave MUL when the counter wraps from 0.
- PACK:
  - Product P is 22 bits, in [2^20, 2^22).
  - Result exponent E = 2e + P[21], held as a 7-bit signed value (range -48..31, no overflow).
  - Fraction = the 10 bits below the leading one.
  - Biased exponent = E + 15.
    - If ≥ 31: result +inf (0x7C00).
    - If ≤ 0: subnormal. Right-shift the full significand by (1 − biased); if the shift is ≥ 12, the result is +0.
- Sign of every numeric result is 0.
- Specials:
  - ±0 → 0x0000.
  - ±inf → 0x7C00.
  - NaN → input sign kept, exponent 0x1F, mantissa | 0x200 (quiet bit set).
- Rounding is controlled by the configuration macro; the default is truncation.
- Reset:
  - `busy` = 0, `valid` = 0, `out_data` = 0x0000, state IDLE, datapath registers cleared.
  - Reset mid-operation aborts the operation; no `valid` is produced.

## Timing
- `start` accepted at edge k:
  - Numeric path: `valid` is asserted by edge k+12 (latency 12).
  - Special or zero path: `valid` is asserted by edge k+1 (latency 1).
- `busy` deasserts on the same edge that asserts `valid`.
- A new `start` may be accepted on the first edge after that, i.e. `start` held high continuously gives one result per 13 cycles.
- `start` together with a reset release is ignored. The first accept occurs on a clock edge with `rst_n` already high.
- `out_data` changes only on the edge that asserts `valid`.

## Configuration
- `FP16_SQUARE_ROUND_EN`:
  - Defined: round-to-nearest-even using guard and sticky bits taken from the discarded product or subnormal-shift bits.
    - A mantissa carry-out increments the exponent.
    - Rounding up to biased exponent 31 produces +inf.
    - A subnormal rounding up becomes min-normal 0x0400.
  - Undefined: truncation. The guard/sticky logic is absent.
- Latency is identical in both builds.

## Structure
- Shared package `fp16_sq_pkg`:
  - State enum (IDLE, MUL, PACK).
  - `FP16_BIAS` = 15, `FP16_EXP_MAX` = 5'h1F, `FP16_QNAN_BIT` = 10'h200, `FP16_PINF` = 16'h7C00.
  - `MUL_ITERS` = 11.
- One sub-module, `fp16_sq_pack`:
  - Combinational.
  - Maps P, E and the special flags to the 16-bit result, including normalize, subnormal shift and optional rounding.
  - The top level holds the FSM, counter and datapath registers.

## Test plan
- 0x4200 (3.0) → 0x4880 (9.0); `valid` exactly 12 edges after accept; `busy` high for 12 cycles.
- 0xC000 (−2.0) → 0x4400. Then 0x7BFF → 0x7C00 (overflow).
- 0xFC00 → 0x7C00, 0x8000 → 0x0000, 0x7D00 → 0x7F00, 0xFD00 → 0xFF00; each with latency 1.
- Underflow:
  - 0x2000 → 0x0400.
  - 0x1C00 → 0x0100 (subnormal).
  - 0x0001 → 0x0000.
- 0x3E01 → 0x4081 without the macro, 0x4082 with `FP16_SQUARE_ROUND_EN`.
- Control:
  - `start` pulsed while `busy` is ignored; the first result is unaffected.
  - `rst_n` low at MUL cycle 5 → no `valid`, `out_data` = 0, IDLE.
  - Back-to-back accepts are 13 cycles apart.
